// File: rtl/sdram_read_pkg.sv
// Shared types, widths and state codes for the SDRAM read engine.
package sdram_read_pkg;
  localparam int DELAY_W = 16;
  localparam int SIZE_W  = 24;
  localparam int ADDR_W  = 22;

  localparam logic [2:0] ST_IDLE            = 3'd0;
  localparam logic [2:0] ST_WAIT            = 3'd1;
  localparam logic [2:0] ST_ACTIVATE        = 3'd2;
  localparam logic [2:0] ST_READ_COMMAND    = 3'd3;
  localparam logic [2:0] ST_READ_TOP        = 3'd4;
  localparam logic [2:0] ST_READ_BOTTOM     = 3'd5;
  localparam logic [2:0] ST_BURST_TERMINATE = 3'd6;
  localparam logic [2:0] ST_PRECHARGE       = 3'd7;

  // One capture token per 16-bit beat; bottom marks the second half of a word.
  typedef struct packed {
    logic valid;
    logic bottom;
  } token_t;

  function automatic logic [31:0] pack_debug(input logic [15:0] data_lo,
                                             input logic [2:0]  state,
                                             input logic        wr,
                                             input logic        en,
                                             input logic [2:0]  cmd,
                                             input logic        act);
    return {6'd0, act, cmd, en, wr, 1'b0, state, data_lo};
  endfunction
endpackage

// File: rtl/sdram_include.v
// Shared SDRAM command encodings ({ras_n, cas_n, we_n}) and timing, in clocks.
`ifndef SDRAM_INCLUDE_V
`define SDRAM_INCLUDE_V
`define SDRAM_CMD_NOP  3'b111
`define SDRAM_CMD_ACT  3'b011
`define SDRAM_CMD_READ 3'b101
`define SDRAM_CMD_TERM 3'b110
`define SDRAM_CMD_PRE  3'b010
`define T_RCD 2
`define T_RP  2
`define T_CAS 2
`endif

// File: rtl/sdram_read_pipe.sv
// CAS-latency delay line: a token pushed in emerges DEPTH cycles later.
`include "sdram_include.v"

module sdram_read_pipe
  import sdram_read_pkg::*;
#(
  parameter int DEPTH = `T_CAS + 1
) (
  input  logic   clk_i,
  input  logic   clear_i,
  input  token_t tok_i,
  output token_t tok_o,
  output logic   busy_o
);
  token_t [DEPTH-1:0] stage_q;

  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      stage_q <= '0;
    end else begin
      stage_q <= {stage_q[DEPTH-2:0], tok_i};
    end
  end

  assign tok_o = stage_q[DEPTH-1];

  always_comb begin
    busy_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) busy_o = busy_o | stage_q[i].valid;
  end
endmodule

// File: rtl/sdram_read.sv
// SDRAM read engine: streams fifo_size 32-bit words from app_address into a FIFO
// as page-bounded 16-bit bursts, yielding to auto refresh between bursts.
`include "sdram_include.v"

module sdram_read
  import sdram_read_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] debug,
  output logic [2:0]  command,
  output logic [11:0] address,
  output logic [1:0]  bank,
  output logic [1:0]  data_mask,
  input  logic [15:0] data_in,
  output logic        idle,
  input  logic        enable,
  input  logic [21:0] app_address,
  input  logic        auto_refresh,
  output logic        wait_for_refresh,
  output logic [31:0] fifo_data,
  output logic        fifo_write,
  input  logic        fifo_ready,
  output logic        fifo_activate,
  input  logic [23:0] fifo_size
);
  logic [2:0]         state_q, state_d;
  logic [DELAY_W-1:0] delay_q, delay_d;
  logic [SIZE_W-1:0]  req_count_q, req_count_d;
  logic [SIZE_W-1:0]  wr_count_q, wr_count_d;
  logic [ADDR_W-1:0]  read_address_q, read_address_d;
  logic [2:0]         command_q, command_d;
  logic [11:0]        address_q, address_d;
  logic [1:0]         bank_q, bank_d;
  logic               fifo_activate_q, fifo_activate_d;
  logic               wfr_q, wfr_d;
  logic [31:0]        fifo_data_q, fifo_data_d;
  logic               fifo_write_q, fifo_write_d;
  logic [15:0]        top_q, top_d;
  logic               wr_clear;
  token_t             issue_tok, cap_tok;
  logic               pipe_busy;

  sdram_read_pipe u_pipe (
    .clk_i   (clk),
    .clear_i (rst),
    .tok_i   (issue_tok),
    .tok_o   (cap_tok),
    .busy_o  (pipe_busy)
  );

  // Handshake: in WAIT, fifo_ready requests a fill; fifo_activate then stays high
  // until fifo_size words have been written. The consumer lowers fifo_ready once it
  // sees fifo_activate, otherwise a new fill starts right after the drop.
  always_comb begin
    state_d         = state_q;
    delay_d         = delay_q;
    req_count_d     = req_count_q;
    read_address_d  = read_address_q;
    command_d       = `SDRAM_CMD_NOP;
    address_d       = address_q;
    bank_d          = bank_q;
    fifo_activate_d = fifo_activate_q;
    wfr_d           = 1'b0;
    wr_clear        = 1'b0;
    issue_tok       = '0;
    if (delay_q != '0) begin
      delay_d = delay_q - 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          wfr_d = 1'b1;
          if (enable) begin
            read_address_d = app_address;
            state_d        = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (auto_refresh) begin
            wfr_d = 1'b1;
          end else if (!fifo_activate_q) begin
            if (fifo_ready) begin
              fifo_activate_d = 1'b1;
              req_count_d     = '0;
              wr_clear        = 1'b1;
            end else if (!enable) begin
              state_d = ST_IDLE;
            end
          end else if (req_count_q < fifo_size) begin
            state_d = ST_ACTIVATE;
          end else if (wr_count_q == fifo_size) begin
            fifo_activate_d = 1'b0;
            delay_d         = DELAY_W'(1);
          end
        end
        ST_ACTIVATE: begin
          command_d = `SDRAM_CMD_ACT;
          bank_d    = read_address_q[21:20];
          address_d = read_address_q[19:8];
          delay_d   = DELAY_W'(`T_RCD);
          state_d   = ST_READ_COMMAND;
        end
        ST_READ_COMMAND: begin
          command_d        = `SDRAM_CMD_READ;
          address_d        = {4'h0, read_address_q[7:0]};
          issue_tok.valid  = 1'b1;
          state_d          = ST_READ_BOTTOM;
        end
        ST_READ_TOP: begin
          issue_tok.valid = 1'b1;
          state_d         = ST_READ_BOTTOM;
        end
        ST_READ_BOTTOM: begin
          issue_tok.valid  = 1'b1;
          issue_tok.bottom = 1'b1;
          req_count_d      = req_count_q + 1'b1;
          read_address_d   = read_address_q + 22'd2;
          // Stop at the page end so the next word reopens the following row.
          if (read_address_q[7:0] == 8'hFE || auto_refresh || req_count_d == fifo_size)
            state_d = ST_BURST_TERMINATE;
          else
            state_d = ST_READ_TOP;
        end
        ST_BURST_TERMINATE: begin
          command_d = `SDRAM_CMD_TERM;
          delay_d   = DELAY_W'(`T_CAS);
          state_d   = ST_PRECHARGE;
        end
        ST_PRECHARGE: begin
          command_d = `SDRAM_CMD_PRE;
          delay_d   = DELAY_W'(`T_RP);
          state_d   = ST_WAIT;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    top_d        = top_q;
    fifo_data_d  = fifo_data_q;
    fifo_write_d = 1'b0;
    if (cap_tok.valid) begin
      if (cap_tok.bottom) begin
        fifo_data_d  = {top_q, data_in};
        fifo_write_d = 1'b1;
      end else begin
        top_d = data_in;
      end
    end
    wr_count_d = wr_clear ? '0 : wr_count_q + {{(SIZE_W-1){1'b0}}, fifo_write_q};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      delay_q         <= '0;
      req_count_q     <= '0;
      wr_count_q      <= '0;
      read_address_q  <= '0;
      command_q       <= `SDRAM_CMD_NOP;
      address_q       <= '0;
      bank_q          <= '0;
      fifo_activate_q <= 1'b0;
      wfr_q           <= 1'b0;
      fifo_data_q     <= '0;
      fifo_write_q    <= 1'b0;
      top_q           <= '0;
    end else begin
      state_q         <= state_d;
      delay_q         <= delay_d;
      req_count_q     <= req_count_d;
      wr_count_q      <= wr_count_d;
      read_address_q  <= read_address_d;
      command_q       <= command_d;
      address_q       <= address_d;
      bank_q          <= bank_d;
      fifo_activate_q <= fifo_activate_d;
      wfr_q           <= wfr_d;
      fifo_data_q     <= fifo_data_d;
      fifo_write_q    <= fifo_write_d;
      top_q           <= top_d;
    end
  end

  assign command          = command_q;
  assign address          = address_q;
  assign bank             = bank_q;
  assign data_mask        = 2'b00;
  assign fifo_data        = fifo_data_q;
  assign fifo_write       = fifo_write_q;
  assign fifo_activate    = fifo_activate_q;
  assign wait_for_refresh = wfr_q;
  assign idle = (delay_q == '0) && (state_q == ST_IDLE || state_q == ST_WAIT) && !pipe_busy;
  assign debug = pack_debug(fifo_data_q[15:0], state_q, fifo_write_q, enable, command_q,
                            fifo_activate_q);
endmodule

// File: doc/sdram_read.md
SDRAM_READ -- requirements
Module: sdram_read

Interface
REQ-001 SHALL provide: clk  in  1  single clock; all logic on rising edge.
REQ-002 SHALL provide: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL provide: debug  out  32  [15:0] fifo_data[15:0], [19:16] state, [20] fifo_write, [21] enable, [24:22] command, [25] fifo_activate, rest 0.
REQ-004 SHALL provide: command  out  3  SDRAM command (NOP/ACT/READ/TERM/PRE codes); address  out  12; bank  out  2; data_mask  out  2, held 2'b00.
REQ-005 SHALL provide: data_in  in  16  SDRAM DQ capture.
REQ-006 SHALL provide: idle  out  1; enable  in  1; app_address  in  22  {bank[21:20], row[19:8], column[7:0]}; auto_refresh  in  1; wait_for_refresh  out  1.
REQ-007 SHALL provide: fifo_data  out  32  {top, bottom}; fifo_write  out  1; fifo_ready  in  1; fifo_activate  out  1; fifo_size  in  24  capacity in 32-bit words.

Function
REQ-008 States SHALL be IDLE, WAIT, ACTIVATE, READ_COMMAND, READ_TOP, READ_BOTTOM, BURST_TERMINATE, PRECHARGE; any other state -> IDLE.
REQ-009 A 16-bit delay counter SHALL, while nonzero, force command=NOP, decrement, and freeze state; capture pipeline keeps running.
REQ-010 IDLE: on enable, latch app_address into read_address, go WAIT; wait_for_refresh=1 every IDLE cycle.
REQ-011 WAIT: auto_refresh high -> wait_for_refresh=1, no other action; else if !fifo_activate and fifo_ready -> fifo_activate=1, req_count=0, wr_count=0; else if !fifo_activate and !enable -> IDLE.
REQ-012 WAIT with fifo_activate: req_count<fifo_size -> ACTIVATE; else if wr_count==fifo_size -> fifo_activate=0, delay=1.
REQ-013 ACTIVATE: command=ACT, bank=read_address[21:20], address=row, delay=`T_RCD, -> READ_COMMAND.
REQ-014 READ_COMMAND: command=READ, address={4'h0, column}, issue top-beat token, -> READ_BOTTOM.
REQ-015 READ_TOP: command=NOP, issue top token, -> READ_BOTTOM.
REQ-016 READ_BOTTOM: command=NOP, issue bottom token, req_count+1, read_address+2 (full 22-bit add, carries into row/bank).
REQ-017 READ_BOTTOM exit: column==8'hFE or auto_refresh or req_count+1==fifo_size -> BURST_TERMINATE; else -> READ_TOP.
REQ-018 BURST_TERMINATE: command=TERM, delay=`T_CAS, -> PRECHARGE; PRECHARGE: command=PRE, delay=`T_RP, -> WAIT.
REQ-019 Capture: each token SHALL emerge exactly `T_CAS+1 cycles after issue; top token latches data_in to top half; bottom token drives fifo_data={top, data_in} and fifo_write=1 for one cycle.
REQ-020 fifo_write SHALL be 0 every other cycle; wr_count increments per fifo_write; in-flight tokens at TERM SHALL still be captured.
REQ-021 Total fifo_write pulses per activation SHALL never exceed fifo_size.
REQ-022 fifo_size==0 on activation: no ACT issued; fifo_activate drops next WAIT cycle.
REQ-023 idle SHALL = (delay==0) && state in {IDLE, WAIT} && capture pipeline empty.

Reset
REQ-024 On rst: command=NOP, address=0, bank=0, data_mask=0, fifo_data=0, fifo_write=0, fifo_activate=0, wait_for_refresh=0, delay=0, counters=0, read_address=0, state=IDLE, pipeline tokens cleared.
REQ-025 rst mid-burst SHALL take effect next edge; no fifo_write from tokens issued before rst.

Structure
REQ-026 Command codes (`SDRAM_CMD_*) and timing constants (`T_RCD, `T_RP, `T_CAS) SHALL come from shared sdram_include.v; none redefined locally.
REQ-027 CAS-latency token delay line SHALL be sub-module sdram_read_pipe (token valid + top/bottom tag, depth `T_CAS+1, synchronous clear).

Verification
REQ-028 app_address=22'h212344, fifo_size=4, model returns 16'h1111..16'h8888 -> ACT bank 2 row 12'h123, READ addr 12'h044, fifo_data 32'h11112222, 33334444, 55556666, 77778888, then TERM, PRE, fifo_activate=0.
REQ-029 app_address=22'h0000FC, fifo_size=8 -> 2 words, TERM, PRE, ACT row 12'h001, READ addr 12'h000, 6 more words; 8 pulses total.
REQ-030 auto_refresh rises after word 2 of fifo_size=16 -> TERM after that bottom beat, in-flight word written, WAIT with wait_for_refresh=1; after drop, resumes at next address, 16 pulses total.
REQ-031 fifo_size=0 with fifo_ready=1 -> no ACT/READ command, fifo_activate pulses high then low, zero fifo_write.
REQ-032 rst asserted one cycle after READ command -> next cycle command=NOP, fifo_write=0 for all following cycles, state=IDLE.
REQ-033 enable dropped with no active FIFO -> IDLE within 1 cycle, idle=1, wait_for_refresh=1.
